// File: rtl/tetris.sv
// Opcode encoding shared between the command generator and the tile engine.
package tetris;

  typedef enum logic [2:0] {
    eNOP     = 3'd0,
    eNewTile = 3'd1,
    eRotate  = 3'd2,
    eLeft    = 3'd3,
    eRight   = 3'd4,
    eDown    = 3'd5,
    eClear   = 3'd6
  } tile_opcode_e;

endpackage

// File: rtl/tile_cmd_gen.sv
// Tile command generator: turns buttons, gravity and a random tile source into a
// serial stream of engine opcodes, one outstanding command at a time.
module tile_cmd_gen
  import tetris::*;
#(
  parameter int unsigned fall_period_p = 1000,
  parameter logic [3:0]  spawn_col_p   = 4'd3,
  parameter logic [7:0]  lfsr_seed_p   = 8'hA5
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         btn_rotate_i,
  input  logic         btn_left_i,
  input  logic         btn_right_i,
  input  logic         btn_down_i,
  output logic         op_v_o,
  output tile_opcode_e op_o,
  output logic [6:0]   operand_o,
  input  logic         op_ready_i,
  input  logic         done_v_i,
  input  logic         done_blocked_i,
  input  logic [2:0]   done_lines_i,
  output logic         game_over_o,
  output logic [15:0]  lines_o
);

  localparam int unsigned GRAV_W  = $clog2(fall_period_p);
  localparam int unsigned PEND_W  = 4;
  localparam int unsigned P_DOWN  = 3;
  localparam int unsigned P_ROT   = 2;
  localparam int unsigned P_LEFT  = 1;
  localparam int unsigned P_RIGHT = 0;
  localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(fall_period_p - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_PLAY, S_ISSUE, S_WAIT, S_CLEAR, S_OVER
  } state_e;

  state_e              r_state, w_state_nxt;
  tile_opcode_e        r_op, w_op_nxt, w_sel_op;
  logic [6:0]          r_operand, w_operand_nxt;
  logic                r_op_v, w_op_v_nxt;
  logic                r_game_over;
  logic [7:0]          r_lfsr;
  logic                w_lfsr_fb;
  logic [2:0]          w_type;
  logic [PEND_W-1:0]   r_btn_q, w_btn, w_rise;
  logic [PEND_W-1:0]   r_pend, w_pend_nxt, w_pend_set, w_pend_clr, w_op_mask;
  logic [GRAV_W-1:0]   r_grav, w_grav_nxt;
  logic                w_grav_run, w_tick, w_in_game;
  logic [15:0]         r_lines, w_lines_nxt;
  logic [16:0]         w_lines_sum;
  logic                w_xfer, w_spawn_entry, w_start_game, w_clear_done;

  assign op_v_o      = r_op_v;
  assign op_o        = r_op;
  assign operand_o   = r_operand;
  assign game_over_o = r_game_over;
  assign lines_o     = r_lines;

  assign w_xfer    = r_op_v & op_ready_i;
  assign w_in_game = (r_state != S_IDLE) && (r_state != S_OVER);
  assign w_btn     = {btn_down_i, btn_rotate_i, btn_left_i, btn_right_i};
  assign w_rise    = w_btn & ~r_btn_q;
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_type    = (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];

  // Fixed priority: down > rotate > left > right.
  always_comb begin
    w_sel_op = eNOP;
    if (r_pend[P_DOWN])       w_sel_op = eDown;
    else if (r_pend[P_ROT])   w_sel_op = eRotate;
    else if (r_pend[P_LEFT])  w_sel_op = eLeft;
    else if (r_pend[P_RIGHT]) w_sel_op = eRight;
  end

  always_comb begin
    w_op_mask = '0;
    case (r_op)
      eDown:   w_op_mask[P_DOWN]  = 1'b1;
      eRotate: w_op_mask[P_ROT]   = 1'b1;
      eLeft:   w_op_mask[P_LEFT]  = 1'b1;
      eRight:  w_op_mask[P_RIGHT] = 1'b1;
      default: w_op_mask = '0;
    endcase
  end

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_operand_nxt = r_operand;
    w_pend_clr    = '0;
    unique case (r_state)
      S_IDLE, S_OVER: if (start_i) w_state_nxt = S_SPAWN;
      S_SPAWN:        if (w_xfer) w_state_nxt = S_WAIT;
      S_PLAY: begin
        if (|r_pend) begin
          w_state_nxt   = S_ISSUE;
          w_op_nxt      = w_sel_op;
          w_operand_nxt = '0;
        end
      end
      S_ISSUE: begin
        if (w_xfer) begin
          w_state_nxt = S_WAIT;
          w_pend_clr  = w_op_mask;
        end
      end
      S_WAIT: begin
        if (done_v_i) begin
          case (r_op)
            eNewTile: w_state_nxt = done_blocked_i ? S_OVER : S_PLAY;
            eDown:    w_state_nxt = done_blocked_i ? S_CLEAR : S_PLAY;
            eClear:   w_state_nxt = S_SPAWN;
            default:  w_state_nxt = S_PLAY;
          endcase
        end
      end
      S_CLEAR: if (w_xfer) w_state_nxt = S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase

    w_spawn_entry = (w_state_nxt == S_SPAWN) && (r_state != S_SPAWN);
    w_start_game  = w_spawn_entry && !w_in_game;
    if (w_spawn_entry) begin
      w_op_nxt      = eNewTile;
      w_operand_nxt = {spawn_col_p, w_type};
    end else if ((w_state_nxt == S_CLEAR) && (r_state != S_CLEAR)) begin
      w_op_nxt      = eClear;
      w_operand_nxt = '0;
    end else if ((w_state_nxt == S_OVER) && (r_state != S_OVER)) begin
      w_op_nxt      = eNOP;
      w_operand_nxt = '0;
    end
    w_op_v_nxt = (w_state_nxt == S_SPAWN) || (w_state_nxt == S_ISSUE) ||
                 (w_state_nxt == S_CLEAR);
  end

  // Gravity pauses while the engine is collapsing cleared rows.
  always_comb begin
    w_grav_run = w_in_game && !((r_state == S_WAIT) && (r_op == eClear));
    w_tick     = w_grav_run && (r_grav == GRAV_LAST);
    if ((r_state == S_SPAWN) && w_xfer) w_grav_nxt = '0;
    else if (w_tick)                    w_grav_nxt = '0;
    else if (w_grav_run)                w_grav_nxt = r_grav + GRAV_W'(1);
    else                                w_grav_nxt = r_grav;
  end

  // New edges win over the clear of the issued bit so a re-press is not lost.
  always_comb begin
    w_pend_set = (w_in_game ? w_rise : '0) | {w_tick, 3'b000};
    w_pend_nxt = w_spawn_entry ? '0 : ((r_pend & ~w_pend_clr) | w_pend_set);
  end

  always_comb begin
    w_clear_done = (r_state == S_WAIT) && done_v_i && (r_op == eClear);
    w_lines_sum  = {1'b0, r_lines} + 17'(done_lines_i);
    if (w_clear_done)     w_lines_nxt = w_lines_sum[16] ? 16'hFFFF : w_lines_sum[15:0];
    else if (w_start_game) w_lines_nxt = '0;
    else                   w_lines_nxt = r_lines;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_op        <= eNOP;
      r_operand   <= '0;
      r_op_v      <= 1'b0;
      r_game_over <= 1'b0;
      r_lfsr      <= lfsr_seed_p;
      r_btn_q     <= '0;
      r_pend      <= '0;
      r_grav      <= '0;
      r_lines     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_operand   <= w_operand_nxt;
      r_op_v      <= w_op_v_nxt;
      r_game_over <= (w_state_nxt == S_OVER);
      r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
      r_btn_q     <= w_btn;
      r_pend      <= w_pend_nxt;
      r_grav      <= w_grav_nxt;
      r_lines     <= w_lines_nxt;
    end
  end

endmodule

// File: tb/tb_tile_cmd_gen.sv
// Directed bench for tile_cmd_gen: table of per-cycle vectors plus sequences for
// priority, clear/saturation, game-over and reset-during-handshake.
module tb_tile_cmd_gen;
  import tetris::*;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic         btn_rotate_i = 1'b0, btn_left_i = 1'b0, btn_right_i = 1'b0, btn_down_i = 1'b0;
  logic         op_v_o;
  tile_opcode_e op_o;
  logic [6:0]   operand_o;
  logic         op_ready_i = 1'b0;
  logic         done_v_i = 1'b0;
  logic         done_blocked_i = 1'b0;
  logic [2:0]   done_lines_i = 3'd0;
  logic         game_over_o;
  logic [15:0]  lines_o;

  int n_chk = 0;
  int n_err = 0;

  tile_cmd_gen #(.fall_period_p(64), .spawn_col_p(4'd3), .lfsr_seed_p(8'hA5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .btn_rotate_i(btn_rotate_i), .btn_left_i(btn_left_i),
    .btn_right_i(btn_right_i), .btn_down_i(btn_down_i),
    .op_v_o(op_v_o), .op_o(op_o), .operand_o(operand_o), .op_ready_i(op_ready_i),
    .done_v_i(done_v_i), .done_blocked_i(done_blocked_i), .done_lines_i(done_lines_i),
    .game_over_o(game_over_o), .lines_o(lines_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         start, rdy, dv, blk;
    logic [3:0]   btn;      // {down, rotate, left, right}
    logic         exp_v, cop;
    tile_opcode_e exp_op;
    logic [6:0]   exp_opd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic rdy, input logic dv, input logic blk,
                              input logic [3:0] btn, input logic ev, input logic cop,
                              input tile_opcode_e op, input logic [6:0] opd);
    vec_t v;
    v.start = st; v.rdy = rdy; v.dv = dv; v.blk = blk; v.btn = btn;
    v.exp_v = ev; v.cop = cop; v.exp_op = op; v.exp_opd = opd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_down_i, btn_rotate_i, btn_left_i, btn_right_i} = b;
  endtask

  // Wait (bounded) for a command, check it, accept it, then return done.
  task automatic do_cmd(input string nm, input tile_opcode_e op, input logic blk,
                        input logic [2:0] ln);
    int n = 0;
    while (!op_v_o && n < 8) begin
      tick();
      n++;
    end
    chk({nm, "_valid"}, 32'(op_v_o), 32'd1);
    chk({nm, "_op"}, 32'(op_o), 32'(op));
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;
    chk({nm, "_xfer"}, 32'(op_v_o), 32'd0);
    done_v_i = 1'b1; done_blocked_i = blk; done_lines_i = ln;
    tick();
    done_v_i = 1'b0; done_blocked_i = 1'b0; done_lines_i = 3'd0;
  endtask

  initial begin
    tile_opcode_e last_op;
    logic [15:0]  exp_lines;
    int           add, cyc;
    logic         saw_v;

    // start, rdy, dv, blk, btn, exp_v, cop, exp_op, exp_operand
    vq.push_back(mk(1, 1, 0, 0, 4'b0000, 1, 1, eNewTile, 7'h1D));
    vq.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 0, 1, 0, 4'b0000, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 0, 0, 0, 4'b0010, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 0, 0, 0, 4'b0010, 1, 1, eLeft, 7'h00));
    for (int i = 0; i < 10; i++) vq.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 1, eLeft, 7'h00));
    vq.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 0, 1, 1, 4'b0000, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 0, 0, 0, 4'b0001, 0, 0, eNOP, 7'h00));
    vq.push_back(mk(0, 1, 0, 0, 4'b0001, 1, 1, eRight, 7'h00));
    vq.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, eNOP, 7'h00));

    // Reset state
    repeat (3) tick();
    chk("rst_v", 32'(op_v_o), 32'd0);
    chk("rst_op", 32'(op_o), 32'(eNOP));
    chk("rst_operand", 32'(operand_o), 32'd0);
    chk("rst_over", 32'(game_over_o), 32'd0);
    chk("rst_lines", 32'(lines_o), 32'd0);

    reset_i = 1'b0;
    foreach (vq[i]) begin
      start_i = vq[i].start; op_ready_i = vq[i].rdy;
      done_v_i = vq[i].dv; done_blocked_i = vq[i].blk;
      set_btn(vq[i].btn);
      tick();
      chk($sformatf("row%0d_v", i), 32'(op_v_o), 32'(vq[i].exp_v));
      if (vq[i].cop) begin
        chk($sformatf("row%0d_op", i), 32'(op_o), 32'(vq[i].exp_op));
        chk($sformatf("row%0d_operand", i), 32'(operand_o), 32'(vq[i].exp_opd));
      end
    end
    start_i = 0; op_ready_i = 0; done_v_i = 0; done_blocked_i = 0; set_btn(4'b0000);

    // Rotate+left edges and a gravity tick all land while waiting
    set_btn(4'b0110);
    tick();
    set_btn(4'b0000);
    for (int i = 0; i < 70; i++) tick();
    chk("prio_hold", 32'(op_v_o), 32'd0);
    done_v_i = 1'b1;
    tick();
    done_v_i = 1'b0;
    do_cmd("prio_down", eDown, 1'b0, 3'd0);
    do_cmd("prio_rot", eRotate, 1'b0, 3'd0);
    do_cmd("prio_left", eLeft, 1'b0, 3'd0);
    repeat (3) tick();
    chk("prio_empty", 32'(op_v_o), 32'd0);

    // Landing -> clear of 3 lines -> respawn
    set_btn(4'b1000);
    do_cmd("land_down", eDown, 1'b1, 3'd0);
    set_btn(4'b0000);
    chk("clear_operand", 32'(operand_o), 32'd0);
    do_cmd("clear3", eClear, 1'b0, 3'd3);
    chk("clear3_lines", 32'(lines_o), 32'd3);
    chk("respawn_v", 32'(op_v_o), 32'd1);
    chk("respawn_op", 32'(op_o), 32'(eNewTile));
    chk("respawn_col", 32'(operand_o[6:3]), 32'd3);

    // Drive the line count up to 16'hFFFE with a free-running responder
    op_ready_i = 1'b1; done_v_i = 1'b1;
    last_op = eNOP; exp_lines = 16'd3; cyc = 0;
    while (exp_lines != 16'hFFFE && cyc < 80000) begin
      done_blocked_i = (last_op == eDown);
      btn_down_i = ~btn_down_i;
      if (op_v_o) begin
        last_op = op_o;
        if (op_o == eClear) begin
          add = (int'(16'hFFFE - exp_lines) > 7) ? 7 : int'(16'hFFFE - exp_lines);
          done_lines_i = 3'(add);
          exp_lines = exp_lines + 16'(add);
        end
      end
      tick();
      cyc++;
    end
    done_blocked_i = 1'b0;
    tick();
    op_ready_i = 1'b0; done_v_i = 1'b0; done_lines_i = 3'd0; btn_down_i = 1'b0;
    chk("near_sat_lines", 32'(lines_o), 32'h0000FFFE);
    chk("near_sat_spawn", 32'(op_v_o), 32'd1);

    do_cmd("sat_spawn", eNewTile, 1'b0, 3'd0);
    set_btn(4'b1000);
    do_cmd("sat_down", eDown, 1'b1, 3'd0);
    set_btn(4'b0000);
    do_cmd("sat_clear", eClear, 1'b0, 3'd3);
    chk("sat_lines", 32'(lines_o), 32'h0000FFFF);

    // Spawn collision -> game over; buttons ignored; restart clears lines
    do_cmd("over_spawn", eNewTile, 1'b1, 3'd0);
    chk("over_flag", 32'(game_over_o), 32'd1);
    chk("over_v", 32'(op_v_o), 32'd0);
    saw_v = 1'b0;
    for (int i = 0; i < 80; i++) begin
      set_btn(i[0] ? 4'b1111 : 4'b0000);
      tick();
      if (op_v_o) saw_v = 1'b1;
    end
    set_btn(4'b0000);
    chk("over_quiet", 32'(saw_v), 32'd0);
    chk("over_flag_held", 32'(game_over_o), 32'd1);
    chk("over_lines_held", 32'(lines_o), 32'h0000FFFF);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart_v", 32'(op_v_o), 32'd1);
    chk("restart_op", 32'(op_o), 32'(eNewTile));
    chk("restart_lines", 32'(lines_o), 32'd0);
    chk("restart_over", 32'(game_over_o), 32'd0);

    // Reset while a command is offered; late done must be ignored
    reset_i = 1'b1;
    tick();
    chk("midrst_v", 32'(op_v_o), 32'd0);
    chk("midrst_op", 32'(op_o), 32'(eNOP));
    chk("midrst_operand", 32'(operand_o), 32'd0);
    reset_i = 1'b0; done_v_i = 1'b1; done_blocked_i = 1'b1;
    tick();
    done_v_i = 1'b0; done_blocked_i = 1'b0;
    chk("late_done_v", 32'(op_v_o), 32'd0);
    chk("late_done_over", 32'(game_over_o), 32'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("post_rst_op", 32'(op_o), 32'(eNewTile));
    chk("post_rst_operand", 32'(operand_o), 32'h1A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_cmd_gen.md
# tile_cmd_gen

Command generator sitting directly upstream of the tile engine: turns player buttons, a gravity timer and a pseudo-random tile source into a serial stream of `tetris::tile_opcode_e` commands. It issues one opcode at a time over a valid/ready handshake, then waits for the engine's completion response before issuing the next. It sequences spawn, move, land, line clear and game-over.

## Interface
- `fall_period_p`: default 1000. Cycles between gravity ticks; must be ≥ 2.
- `spawn_col_p`: default 3. Spawn column placed in the `eNewTile` operand; 4 bits.
- `lfsr_seed_p`: default 8'hA5. LFSR reset value; must be nonzero.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `start_i` in 1: starts a game from idle or game-over; ignored otherwise.
- `btn_rotate_i`, `btn_left_i`, `btn_right_i`, `btn_down_i` in 1 each: already-synchronized, debounced button levels.
- `op_v_o` out 1: command valid.
- `op_o` out 3: opcode, of type `tile_opcode_e`.
- `operand_o` out 7: for `eNewTile`, [2:0] is the tile type and [6:3] is the column; 0 for all other opcodes.
- `op_ready_i` in 1: engine accepts the command.
- `done_v_i` in 1: engine finished the last accepted command.
- `done_blocked_i` in 1: qualifies `done_v_i`. For `eNewTile`, 1 means spawn collision. For `eDown`, 1 means the tile landed. For other moves, 1 means the move was rejected.
- `done_lines_i` in 3: lines removed; valid with `done_v_i` after `eClear`.
- `game_over_o` out 1: high in the OVER state.
- `lines_o` out 16: total cleared lines; saturates at 16'hFFFF.

## Operation
- States: IDLE, SPAWN, PLAY, ISSUE, WAIT, CLEAR, OVER.
- IDLE: `op_v_o`=0. `start_i` moves to SPAWN and clears `lines_o` and all pending bits.
- SPAWN: drives `eNewTile` with operand {`spawn_col_p`, type}.
  - type = `lfsr[2:0]`; the value 7 maps to 0.
  - The type is latched on entry to SPAWN and held until transfer.
  - On transfer, go to WAIT.
- PLAY: selects the highest-priority pending bit, latches the corresponding opcode, and goes to ISSUE. With no pending bit it stays in PLAY.
  - Priority: down > rotate > left > right.
- ISSUE: drives the latched opcode. On transfer, clears that pending bit and goes to WAIT.
- WAIT: `op_v_o`=0 and the FSM holds until `done_v_i`. The exit depends on the last opcode:
  - `eNewTile`: blocked → OVER; else → PLAY.
  - `eDown`: blocked → CLEAR; else → PLAY.
  - `eRotate`, `eLeft`, `eRight`: → PLAY regardless of blocked.
  - `eClear`: add `done_lines_i` to `lines_o` (saturating) → SPAWN.
- CLEAR: drives `eClear`. On transfer, go to WAIT.
- OVER: `game_over_o`=1. `start_i` behaves as it does from IDLE.
- Pending bits: one each for rotate, left, right and down.
  - A rising edge of the button (compared with the previous-cycle register) sets its bit in any state except IDLE and OVER.
  - A gravity tick also sets down.
  - A bit that is already set stays set, so multiple edges collapse to one command.
  - All pending bits are cleared on entering SPAWN.
- Gravity counter:
  - Runs in every state except IDLE, OVER and WAIT-after-`eClear`.
  - Reloads to 0 on `eNewTile` transfer.
  - On reaching `fall_period_p`−1 it sets down-pending and wraps to 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every cycle, including IDLE, and is never 0.
- Handshake rules:
  - Transfer occurs when `op_v_o` & `op_ready_i` are both high.
  - While `op_v_o` is high and no transfer has occurred, `op_o` and `operand_o` hold stable.
  - `op_v_o` never drops without a transfer, except on reset.
- `done_v_i` outside WAIT is ignored.

## Timing
- Reset values:
  - state = IDLE
  - `op_v_o`=0, `op_o`=`eNOP`, `operand_o`=0
  - `game_over_o`=0, `lines_o`=0
  - pending bits = 0, gravity counter = 0
  - LFSR = `lfsr_seed_p`, button history = 0
- Reset mid-handshake: `op_v_o` is low in the first cycle after the reset edge; any in-flight command is abandoned.
- `op_o`, `op_v_o` and `game_over_o` are decoded from registered state; there is no combinational path from inputs to outputs.
- `start_i` sampled at edge k → `op_v_o`=1 with `eNewTile` in cycle k+1.
- Transfer at edge t → WAIT in cycle t+1. `done_v_i` at edge t+1 → PLAY in t+2 → ISSUE (`op_v_o`=1) in t+3 if a bit is pending.
- A button edge in cycle c sets its pending bit at edge c+1.

## Test plan
- Reset, then `start_i` pulse with `op_ready_i`=1 and seed 8'hA5 → `op_o`=`eNewTile`, operand = {4'd3, 3'd5} one cycle after start; `op_v_o` low the following cycle.
- Hold `op_ready_i`=0 for 10 cycles during ISSUE of `eLeft` → `op_v_o`, `op_o` and `operand_o` stay constant for all 10 cycles; exactly one transfer occurs when ready rises.
- Rising edges on rotate and left in the same cycle, plus an expiring gravity tick, all while in WAIT → after done, issue order is `eDown`, `eRotate`, `eLeft`.
- `eDown` returns blocked=1 → `eClear` issued; `done_lines_i`=3 → `lines_o` increases by 3, then `eNewTile`; with `lines_o` preset near 16'hFFFE, the result saturates at 16'hFFFF.
- `eNewTile` returns blocked=1 → `game_over_o`=1 and no further `op_v_o`. Button edges are ignored. `start_i` restarts the game with `lines_o`=0.
- Assert `reset_i` while `op_v_o`=1 → next cycle `op_v_o`=0, `op_o`=`eNOP` and state IDLE; a late `done_v_i` is ignored.
